// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the multi-cycle data memory.
// Latches one request at a time, strobes dmem for one cycle and returns the result to the owner.
module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [7:0]  TIMEOUT     = 8'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic        we_q, we_d, owner_q, owner_d, last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        grant_s, grant_port_s, grant_we_s, grant_oor_s;
  logic [31:0] grant_addr_s, grant_wdata_s;
  logic        resp_fire_s, resp_err_s, resp_port_s;
  logic [31:0] resp_data_s;

  // Round-robin grant: on contention the port not granted last wins
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (state_q == S_IDLE) begin
      p0_gnt = p0_req && (!p1_req || last_q);
      p1_gnt = p1_req && (!p0_req || !last_q);
    end else begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end
    grant_s       = p0_gnt || p1_gnt;
    grant_port_s  = p1_gnt;
    grant_we_s    = p1_gnt ? p1_we    : p0_we;
    grant_addr_s  = p1_gnt ? p1_addr  : p0_addr;
    grant_wdata_s = p1_gnt ? p1_wdata : p0_wdata;
    grant_oor_s   = {2'b00, grant_addr_s[31:2]} >= DEPTH_L;
  end

  // Access sequencer: next state, dmem strobes and the response to be registered
  always_comb begin
    state_d     = state_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    we_d        = we_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    m_read      = 1'b0;
    m_write     = 1'b0;
    resp_fire_s = 1'b0;
    resp_err_s  = 1'b0;
    resp_port_s = owner_q;
    resp_data_s = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          m_addr_d  = grant_addr_s;
          m_wdata_d = grant_wdata_s;
          we_d      = grant_we_s;
          owner_d   = grant_port_s;
          last_d    = grant_port_s;
          if (grant_oor_s) begin
            resp_fire_s = 1'b1;
            resp_err_s  = 1'b1;
            resp_port_s = grant_port_s;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // Hold here while dmem is still busy; these cycles are not timed
        if (m_ready) begin
          m_read  = !we_q;
          m_write = we_q;
          cnt_d   = 8'd1;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        // m_ready is stale in the first WAIT cycle: dmem drops it after the strobe edge
        if ((cnt_q != 8'd1) && m_ready) begin
          resp_fire_s = 1'b1;
          resp_data_s = we_q ? 32'h0000_0000 : m_rdata;
          state_d     = S_IDLE;
        end else if (cnt_q >= TIMEOUT) begin
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rsp_valid_d = {resp_fire_s && resp_port_s, resp_fire_s && !resp_port_s};
    err_d       = {resp_fire_s && resp_err_s && resp_port_s,
                   resp_fire_s && resp_err_s && !resp_port_s};
    if (resp_fire_s && !resp_port_s) begin
      rdata0_d = resp_data_s;
      rdata1_d = 32'h0000_0000;
    end else if (resp_fire_s && resp_port_s) begin
      rdata0_d = 32'h0000_0000;
      rdata1_d = resp_data_s;
    end else begin
      rdata0_d = 32'h0000_0000;
      rdata1_d = 32'h0000_0000;
    end
  end

  // State, latched access and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m_addr_q    <= 32'h0000_0000;
      m_wdata_q   <= 32'h0000_0000;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      rsp_valid_q <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= 32'h0000_0000;
      rdata1_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_err       = err_q[0];
  assign p1_err       = err_q[1];
  assign p0_rdata     = rdata0_q;
  assign p1_rdata     = rdata1_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 3-cycle dmem model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rsp_valid, p0_err, p1_gnt, p1_rsp_valid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] m_addr, m_wdata;
  logic        m_read, m_write, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dmem model: a strobe drops ready for three cycles, then ready returns unless hung
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [2:0]  dcnt    = 3'd0;
  logic        m_ready = 1'b1;
  logic [31:0] m_rdata = 32'h0;
  logic        hang    = 1'b0;

  always @(posedge clk) begin
    if (m_write) begin
      mem[m_addr[9:2]] <= m_wdata;
      dcnt <= 3'd3;
      m_ready <= 1'b0;
    end else if (m_read) begin
      m_rdata <= mem[m_addr[9:2]];
      dcnt <= 3'd3;
      m_ready <= 1'b0;
    end else begin
      if (dcnt != 3'd0) dcnt <= dcnt - 3'd1;
      m_ready <= !hang && (dcnt <= 3'd1);
    end
  end

  dmem_arbiter #(.DEPTH_WORDS(16384), .TIMEOUT(8'd15)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Steps from the grant cycle until port p responds; drops p's request after the grant edge
  task automatic wait_rsp(input int p, input int limit, output int at, output logic [31:0] rd,
                          output logic er, output int strb, output int oth);
    at = -1; rd = 32'h0; er = 1'b0; strb = 0; oth = 0;
    for (int k = 0; k < limit && at < 0; k++) begin
      tick;
      if (k == 0) begin
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
      end
      if (m_read || m_write) strb++;
      if (p == 0 ? p1_rsp_valid : p0_rsp_valid) oth++;
      if (p == 0 ? p0_rsp_valid : p1_rsp_valid) begin
        at = cyc;
        rd = (p == 0) ? p0_rdata : p1_rdata;
        er = (p == 0) ? p0_err : p1_err;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = 32'h0; p1_addr = 32'h0; p0_wdata = 32'h0; p1_wdata = 32'h0;
    tick; tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr: got %h exp 0", m_addr); end
    checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_wdata: got %h exp 0", m_wdata); end
    checks++; if ({m_read, m_write} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b exp 00", {m_read, m_write}); end
    checks++; if ({p0_rsp_valid, p1_rsp_valid, p0_err, p1_err} !== 4'b0000) begin
      errors++; $display("FAIL rst_rsp: got %b exp 0000", {p0_rsp_valid, p1_rsp_valid, p0_err, p1_err}); end
    checks++; if ((p0_rdata | p1_rdata) !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h exp 0", p0_rdata, p1_rdata); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write_read;
    int t0, at, strb, oth; logic [31:0] rd; logic er;
    set_req(0, 1'b1, 32'h40, 32'hDEAD_BEEF); #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b exp 01", {p1_gnt, p0_gnt}); end
    t0 = cyc;
    wait_rsp(0, 20, at, rd, er, strb, oth);
    checks++; if (at - t0 !== 6) begin errors++; $display("FAIL wr_latency: got %0d exp 6", at - t0); end
    checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL wr_rsp: err %b rdata %h exp 0/0", er, rd); end
    checks++; if (strb !== 1) begin errors++; $display("FAIL wr_strobes: got %0d exp 1", strb); end
    checks++; if ({m_addr, m_wdata} !== {32'h40, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_latched: got %h/%h exp 40/deadbeef", m_addr, m_wdata); end
    set_req(0, 1'b0, 32'h40, 32'h0); #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt_at_rsp: got %b exp 1", p0_gnt); end
    t0 = cyc;
    wait_rsp(0, 20, at, rd, er, strb, oth);
    checks++; if (at - t0 !== 6) begin errors++; $display("FAIL rd_latency: got %0d exp 6", at - t0); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h exp deadbeef", rd); end
    checks++; if ({er, oth} !== {1'b0, 32'd0}) begin errors++; $display("FAIL rd_err_other: err %b other %0d exp 0/0", er, oth); end
  endtask

  task automatic test_both_ports;
    int t0, at, strb, oth; logic [31:0] rd; logic er;
    set_req(1, 1'b1, 32'h80, 32'hCAFE_F00D); #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b10) begin errors++; $display("FAIL p1wr_gnt: got %b exp 10", {p1_gnt, p0_gnt}); end
    t0 = cyc;
    wait_rsp(1, 20, at, rd, er, strb, oth);
    checks++; if ({at - t0, er} !== {32'd6, 1'b0}) begin errors++; $display("FAIL p1wr_rsp: lat %0d err %b exp 6/0", at - t0, er); end
    do_reset;
    set_req(0, 1'b0, 32'h40, 32'h0); set_req(1, 1'b0, 32'h80, 32'h0); #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin errors++; $display("FAIL both_first_gnt: got %b exp 01", {p1_gnt, p0_gnt}); end
    t0 = cyc;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 1) p0_req = 1'b0;
      if (k < 6) begin
        checks++; if ({p1_gnt, p0_rsp_valid, p1_rsp_valid} !== 3'b000) begin
          errors++; $display("FAIL both_hold_k%0d: got %b exp 000", k, {p1_gnt, p0_rsp_valid, p1_rsp_valid}); end
      end
    end
    checks++; if ({p1_gnt, p0_rsp_valid, p1_rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL both_second_gnt: got %b exp 110", {p1_gnt, p0_rsp_valid, p1_rsp_valid}); end
    checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL both_p0_data: got %h exp deadbeef", p0_rdata); end
    wait_rsp(1, 20, at, rd, er, strb, oth);
    checks++; if (at - t0 !== 12) begin errors++; $display("FAIL both_p1_latency: got %0d exp 12", at - t0); end
    checks++; if ({rd, er, oth} !== {32'hCAFE_F00D, 1'b0, 32'd0}) begin
      errors++; $display("FAIL both_p1_rsp: data %h err %b other %0d exp cafef00d/0/0", rd, er, oth); end
  endtask

  task automatic test_out_of_range;
    int t0, at, strb, oth; logic [31:0] rd; logic er;
    set_req(1, 1'b0, 32'h0001_0000, 32'h0); #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b10) begin errors++; $display("FAIL oor_gnt: got %b exp 10", {p1_gnt, p0_gnt}); end
    t0 = cyc;
    wait_rsp(1, 10, at, rd, er, strb, oth);
    checks++; if (at - t0 !== 1) begin errors++; $display("FAIL oor_latency: got %0d exp 1", at - t0); end
    checks++; if ({er, rd, strb, oth} !== {1'b1, 32'h0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL oor_rsp: err %b data %h strobes %0d other %0d exp 1/0/0/0", er, rd, strb, oth); end
    set_req(1, 1'b0, 32'h0000_FFFC, 32'h0); #1;
    t0 = cyc;
    wait_rsp(1, 20, at, rd, er, strb, oth);
    checks++; if ({at - t0, er, strb} !== {32'd6, 1'b0, 32'd1}) begin
      errors++; $display("FAIL top_word_read: lat %0d err %b strobes %0d exp 6/0/1", at - t0, er, strb); end
    set_req(0, 1'b1, 32'hFFFF_FFF0, 32'h1234_5678); #1;
    t0 = cyc;
    wait_rsp(0, 10, at, rd, er, strb, oth);
    checks++; if ({at - t0, er, strb} !== {32'd1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL oor_write: lat %0d err %b strobes %0d exp 1/1/0", at - t0, er, strb); end
  endtask

  task automatic test_timeout;
    int t0, at, strb, oth; logic [31:0] rd; logic er;
    set_req(0, 1'b0, 32'h40, 32'h0); #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL to_gnt: got %b exp 1", p0_gnt); end
    t0 = cyc;
    tick;
    p0_req = 1'b0;
    hang = 1'b1;
    checks++; if ({busy, m_read} !== 2'b11) begin errors++; $display("FAIL to_issue: got %b exp 11", {busy, m_read}); end
    wait_rsp(0, 40, at, rd, er, strb, oth);
    checks++; if (at - t0 !== 17) begin errors++; $display("FAIL to_latency: got %0d exp 17", at - t0); end
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_rsp: err %b data %h exp 1/0", er, rd); end
    hang = 1'b0;
    set_req(0, 1'b0, 32'h40, 32'h0); #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL to_regrant: got %b exp 1", p0_gnt); end
    t0 = cyc;
    wait_rsp(0, 20, at, rd, er, strb, oth);
    checks++; if ({at - t0, rd, er} !== {32'd6, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL to_next_access: lat %0d data %h err %b exp 6/deadbeef/0", at - t0, rd, er); end
  endtask

  task automatic test_back_to_back;
    int grants, last_g, exp_port; logic [31:0] exp_addr; logic prev_strb;
    grants = 0; last_g = 0; exp_addr = 32'h0; prev_strb = 1'b0;
    do_reset;
    set_req(0, 1'b0, 32'h40, 32'h0); set_req(1, 1'b0, 32'h80, 32'h0); #1;
    for (int k = 0; k < 200 && grants < 20; k++) begin
      if (p0_gnt || p1_gnt) begin
        exp_port = grants % 2;
        checks++; if ({p1_gnt, p0_gnt} !== ((exp_port == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL b2b_order_%0d: got %b exp port %0d", grants, {p1_gnt, p0_gnt}, exp_port); end
        if (grants > 0) begin
          checks++; if (cyc - last_g !== 6) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d exp 6", grants, cyc - last_g); end
        end
        exp_addr = (exp_port == 1) ? 32'h80 : 32'h40;
        last_g = cyc;
        grants++;
      end else if (busy) begin
        checks++; if (m_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr_stable: got %h exp %h", m_addr, exp_addr); end
      end else begin
        checks++; if (grants != 0) begin errors++; $display("FAIL b2b_idle_gap: got idle without grant exp busy"); end
      end
      checks++; if ((m_read || m_write) && prev_strb) begin errors++; $display("FAIL b2b_strobe_width: got 2 cycles exp 1"); end
      prev_strb = m_read || m_write;
      if (p0_rsp_valid) begin
        checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_p0_data: got %h exp deadbeef", p0_rdata); end
      end
      if (p1_rsp_valid) begin
        checks++; if (p1_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_p1_data: got %h exp cafef00d", p1_rdata); end
      end
      tick;
    end
    checks++; if (grants !== 20) begin errors++; $display("FAIL b2b_count: got %0d exp 20", grants); end
    p0_req = 1'b0; p1_req = 1'b0;
    for (int k = 0; k < 8; k++) tick;
  endtask

  task automatic test_reset_mid;
    int t0, at, strb, oth; logic [31:0] rd; logic er;
    set_req(0, 1'b0, 32'h40, 32'h0); #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b exp 1", p0_gnt); end
    tick; p0_req = 1'b0;
    tick; tick;
    rst_n = 1'b0; #1;
    checks++; if ({busy, m_read, m_write} !== 3'b000) begin errors++; $display("FAIL rm_busy: got %b exp 000", {busy, m_read, m_write}); end
    checks++; if ({m_addr, m_wdata} !== 64'h0) begin errors++; $display("FAIL rm_regs: got %h/%h exp 0/0", m_addr, m_wdata); end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if ({p0_rsp_valid, p1_rsp_valid, p0_err, p1_err, busy} !== 5'b00000) begin
        errors++; $display("FAIL rm_hold_%0d: got %b exp 00000", k, {p0_rsp_valid, p1_rsp_valid, p0_err, p1_err, busy}); end
    end
    rst_n = 1'b1;
    tick;
    set_req(1, 1'b0, 32'h80, 32'h0); #1;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL rm_fresh_gnt: got %b exp 1", p1_gnt); end
    t0 = cyc;
    wait_rsp(1, 20, at, rd, er, strb, oth);
    checks++; if ({at - t0, rd, er, oth} !== {32'd6, 32'hCAFE_F00D, 1'b0, 32'd0}) begin
      errors++; $display("FAIL rm_fresh_rsp: lat %0d data %h err %b other %0d exp 6/cafef00d/0/0", at - t0, rd, er, oth); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_both_ports;
    test_out_of_range;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
